rf_fe_ctrl: RTL

Parametrised RF front-end power/mode controller on the peripheral bus. It is the multi-channel successor to the single LNA control block. Each of N_CH channels has a power-down output and a MODE_W-bit mode output. A per-channel settle sequencer holds each channel in a timed wake-up state after power-on or a mode change, then reports it settled. Settle events are flagged through sticky status bits and a shared interrupt.

---
 rtl/rf_fe_ctrl_if.sv | 15 +
 rtl/rf_fe_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rf_fe_ctrl_if.sv
// Peripheral bus seen by rf_fe_ctrl: one-cycle request, registered one-cycle acknowledge.
interface rf_fe_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              valid;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              wstrb;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output valid, address, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/rf_fe_ctrl.sv
// Multi-channel RF front-end power/mode controller with per-channel settle sequencer.
// Bus access takes one cycle to acknowledge; writes and FSM updates land on the acceptance edge.
module rf_fe_ctrl #(
  parameter int N_CH       = 4,
  parameter int MODE_W     = 3,
  parameter int CNT_W      = 16,
  parameter int SETTLE_RST = 100,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = $clog2(N_CH) + 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  rf_fe_ctrl_if.slave              bus,
  output logic [N_CH-1:0]          pd_o,
  output logic [N_CH*MODE_W-1:0]   mode_o,
  output logic                     irq_o
);

  localparam int CFG_W = MODE_W + 2;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2
  } state_e;

  state_e            state_q  [N_CH];
  state_e            state_d  [N_CH];
  logic [CNT_W-1:0]  cnt_q    [N_CH];
  logic [CNT_W-1:0]  cnt_d    [N_CH];
  logic [CNT_W-1:0]  settle_q [N_CH];
  logic [CNT_W-1:0]  settle_d [N_CH];
  logic [CFG_W-1:0]  cfg_q    [N_CH];
  logic [CFG_W-1:0]  cfg_d    [N_CH];
  logic [N_CH-1:0]   evt_q, evt_d;
  logic [N_CH-1:0]   set_evt;
  logic [N_CH-1:0]   ie;

  logic              ready_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              accept;
  logic              ch_ok;
  logic              wr_en;
  logic [ADDR_W-1:0] ch_idx;
  logic [1:0]        reg_sel;
  logic [MODE_W-1:0] wr_mode;
  logic              unused_wdata;

  // A request is taken only while no acknowledge is pending, so a held valid yields one access.
  assign accept       = bus.valid & ~ready_q;
  assign ch_idx       = bus.address >> 2;
  assign reg_sel      = bus.address[1:0];
  assign ch_ok        = ch_idx < ADDR_W'(N_CH);
  assign wr_en        = accept & bus.wstrb & ch_ok;
  assign wr_mode      = bus.wdata[MODE_W:1];
  assign unused_wdata = ^bus.wdata;

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;

  always_comb begin
    rdata_d = '0;
    if (accept && ch_ok) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_idx == ADDR_W'(i)) begin
          case (reg_sel)
            2'd0:    rdata_d[CFG_W-1:0] = cfg_q[i];
            2'd1:    rdata_d[CNT_W-1:0] = settle_q[i];
            2'd2:    rdata_d[3:0] = {evt_q[i], state_q[i] == ST_ON, state_q[i]};
            default: rdata_d = '0;
          endcase
        end
      end
    end
  end

  always_comb begin
    evt_d   = evt_q;
    set_evt = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      cfg_d[i]    = cfg_q[i];
      settle_d[i] = settle_q[i];

      unique case (state_q[i])
        ST_OFF: begin
          if (wr_en && ch_idx == ADDR_W'(i) && reg_sel == 2'd0 && bus.wdata[0]) begin
            cnt_d[i]   = settle_q[i];
            state_d[i] = ST_WAKE;
          end
        end
        ST_WAKE: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = ST_ON;
            set_evt[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        ST_ON: begin
          if (wr_en && ch_idx == ADDR_W'(i) && reg_sel == 2'd0 && bus.wdata[0]
              && wr_mode != cfg_q[i][MODE_W:1]) begin
            cnt_d[i]   = settle_q[i];
            state_d[i] = ST_WAKE;
          end
        end
        default: state_d[i] = ST_OFF;
      endcase

      if (wr_en && ch_idx == ADDR_W'(i)) begin
        case (reg_sel)
          2'd0: begin
            cfg_d[i] = bus.wdata[CFG_W-1:0];
            // Disable overrides everything, including a settle completing on this edge.
            if (!bus.wdata[0]) begin
              state_d[i] = ST_OFF;
              cnt_d[i]   = '0;
              set_evt[i] = 1'b0;
            end
          end
          2'd1: settle_d[i] = bus.wdata[CNT_W-1:0];
          2'd2: if (bus.wdata[3]) evt_d[i] = 1'b0;
          default: ;
        endcase
      end

      if (set_evt[i]) begin
        evt_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      evt_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]  <= ST_OFF;
        cnt_q[i]    <= '0;
        cfg_q[i]    <= '0;
        settle_q[i] <= CNT_W'(SETTLE_RST);
      end
    end else begin
      ready_q <= accept;
      rdata_q <= rdata_d;
      evt_q   <= evt_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        cfg_q[i]    <= cfg_d[i];
        settle_q[i] <= settle_d[i];
      end
    end
  end

  always_comb begin
    pd_o   = '0;
    mode_o = '0;
    ie     = '0;
    for (int i = 0; i < N_CH; i++) begin
      pd_o[i] = (state_q[i] == ST_OFF);
      ie[i]   = cfg_q[i][MODE_W+1];
      if (state_q[i] != ST_OFF) begin
        mode_o[i*MODE_W +: MODE_W] = cfg_q[i][MODE_W:1];
      end
    end
  end

  assign irq_o = |(evt_q & ie);

endmodule
